rename_stage: RTL and testbench
===============================

# rename_stage

Single-issue register-rename stage that sits directly downstream of `free_list_fifo`. It accepts one decoded instruction per cycle and maps its architectural sources and destination onto physical tags using a speculative map table. New destination tags are popped from the free list. Branch checkpoints (map snapshot plus free-list head) are held here, and on misprediction the stage drives the free list's recover port.

## Interface
- PHYSREG, 128, physical registers; PREG_W = $clog2(PHYSREG)
- AREG, 32, architectural registers; AREG_W = $clog2(AREG)
- NCHKPT, 4, branch checkpoint slots (power of 2); CK_W = $clog2(NCHKPT)

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- dec_valid_i  in  1  decoded instruction valid
- dec_ready_o  out  1  stage can accept this cycle
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  AREG_W  architectural register indices
- dec_rd_we_i  in  1  instruction writes rd
- dec_branch_i  in  1  instruction needs a checkpoint
- fl_alloc_en_o  out  1  pop request to the free list
- fl_alloc_done_i  in  1  pop accepted (same cycle)
- fl_alloc_index_i  in  PREG_W  free-list head tag
- fl_empty_i  in  1  free list empty
- fl_chkpt_head_i / fl_chkpt_tail_i  in  PREG_W  live free-list head/tail
- fl_chkpt_free_count_i  in  PREG_W+1  live free count
- fl_recover_o  out  1  free-list recover strobe
- fl_recover_head_o / fl_recover_tail_o  out  PREG_W  restore values
- fl_recover_free_count_o  out  PREG_W+1  restore count
- ren_valid_o  out  1  renamed instruction valid
- ren_ready_i  in  1  downstream accepts
- ren_prs1_o, ren_prs2_o, ren_prd_o, ren_old_prd_o  out  PREG_W  physical tags
- ren_rd_we_o  out  1  prd allocated
- ren_chkpt_valid_o  out  1  instruction owns a checkpoint
- ren_chkpt_id_o  out  CK_W  owned slot
- recover_i  in  1  mispredict; restore slot recover_id_i
- recover_id_i  in  CK_W  slot to restore
- release_i  in  1  oldest checkpoint resolved correct; free it

## Operation
- Map table: AREG entries × PREG_W. Reset value is map[i] = i, which matches the free list's reset head of AREG.
- need_alloc = dec_rd_we_i && dec_rd_i != 0. Writes to x0 never allocate and x0 always maps to 0.
- ckpt_full = (ck_count == NCHKPT).
- dec_ready_o = !recover_i && (!ren_valid_o || ren_ready_i) && !(need_alloc && fl_empty_i) && !(dec_branch_i && ckpt_full).
- fire = dec_valid_i && dec_ready_o.
- fl_alloc_en_o = fire && need_alloc. If fl_alloc_done_i is low while fl_alloc_en_o is high, that is a protocol error (assertion).
- On fire, the output register captures:
  - prs1 = map[rs1] and prs2 = map[rs2], both read before this cycle's update, so rs == rd yields the old tag.
  - prd = fl_alloc_index_i and old_prd = map[rd]. Both are 0 when !need_alloc.
  - ren_rd_we_o = need_alloc.
  - map[rd] is updated to prd.
- Checkpoint on a branch fire:
  - Slot ck_tail stores the post-update map.
  - snap_head = fl_chkpt_head_i + need_alloc, modulo PHYSREG.
  - ck_tail increments and ck_count increments.
  - ren_chkpt_valid_o = 1 and ren_chkpt_id_o = slot.
- Release: frees the oldest slot (ck_head++, ck_count--). Branches resolve in order. Release when ck_count == 0 is ignored.
- Recover (highest priority):
  - map <= snap_map[recover_id_i].
  - ck_tail <= recover_id_i + 1, so slot id stays live and all younger slots are discarded.
  - ck_count <= (recover_id_i − ck_head) mod NCHKPT, plus 1.
  - ren_valid_o clears and no fire occurs.
  - A simultaneous release_i is applied after the restore, against the surviving slots.
  - If recover_id_i is not a live slot, that is a protocol error (assertion).
- Free-list recover outputs, combinational while recover_i is high:
  - fl_recover_o = recover_i.
  - fl_recover_head_o = snap_head[id].
  - fl_recover_tail_o = fl_chkpt_tail_i. Frees are never undone.
  - fl_recover_free_count_o = fl_chkpt_free_count_i + ((fl_chkpt_head_i − snap_head[id]) mod PHYSREG), computed in PREG_W+1 bits.

## Timing
- Reset state:
  - ren_valid_o = 0 and all ren_* tag and id outputs are 0.
  - ck_head = ck_tail = ck_count = 0.
  - Map is identity.
  - fl_recover_o = 0 when recover_i = 0.
  - dec_ready_o = 1 once inputs are idle.
- Latency: fire in cycle N produces ren_valid_o in cycle N+1. Throughput is 1 per cycle with ren_ready_i high.
- ren_* outputs hold stable while ren_valid_o && !ren_ready_i.
- Combinational paths:
  - ren_ready_i, fl_empty_i and recover_i → dec_ready_o.
  - dec_* → fl_alloc_en_o.
  - recover_* → fl_recover_*.
- Map and checkpoint updates take effect at the clock edge after fire or recover.
- Reset mid-operation discards all in-flight and checkpoint state.

## Test plan
- Post-reset stream:
  - Input: add x5, x1, x2.
  - Expected: prs1 = 1, prs2 = 2, prd = 32, old_prd = 5. Next instruction "x6, x5" gives prs1 = 32, prd = 33.
- Write to x0 and the rs == rd case:
  - "x0 = x3 + x4" gives fl_alloc_en_o = 0, prd = 0, ren_rd_we_o = 0.
  - "x7 = x7 + x7" gives prs1 = prs2 = 7, old_prd = 7, prd = next head.
- Backpressure:
  - Hold ren_ready_i = 0 for 3 cycles. Outputs stay stable, dec_ready_o = 0 and no alloc occurs.
  - With fl_empty_i = 1, a write instruction stalls and a non-writing instruction passes.
- Checkpoint full:
  - 4 branches are accepted with ids 0..3.
  - A 5th branch sees dec_ready_o = 0 until release_i is asserted, after which it gets id 0.
- Recover:
  - Checkpoint id 1 at head 40, then 3 more allocs.
  - recover_i with id 1 gives fl_recover_head_o = 40 and count = live count + 3.
  - The map is restored, a younger slot is discarded, and ren_valid_o is 0 on the next cycle.
- Reset asserted mid-stream with ren_valid_o = 1: ren_valid_o drops asynchronously and the map returns to identity.

Source files
------------

// File: rtl/rename_stage.sv
// Single-issue register rename stage: speculative map table, free-list pops and
// branch checkpoints (map snapshot + free-list head) with misprediction recovery.
module rename_stage #(
    parameter int unsigned PHYSREG = 128,
    parameter int unsigned AREG    = 32,
    parameter int unsigned NCHKPT  = 4,
    localparam int unsigned PREG_W = $clog2(PHYSREG),
    localparam int unsigned AREG_W = $clog2(AREG),
    localparam int unsigned CK_W   = $clog2(NCHKPT)
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [AREG_W-1:0] dec_rs1_i,
    input  logic [AREG_W-1:0] dec_rs2_i,
    input  logic [AREG_W-1:0] dec_rd_i,
    input  logic              dec_rd_we_i,
    input  logic              dec_branch_i,

    output logic              fl_alloc_en_o,
    input  logic              fl_alloc_done_i,
    input  logic [PREG_W-1:0] fl_alloc_index_i,
    input  logic              fl_empty_i,
    input  logic [PREG_W-1:0] fl_chkpt_head_i,
    input  logic [PREG_W-1:0] fl_chkpt_tail_i,
    input  logic [PREG_W:0]   fl_chkpt_free_count_i,
    output logic              fl_recover_o,
    output logic [PREG_W-1:0] fl_recover_head_o,
    output logic [PREG_W-1:0] fl_recover_tail_o,
    output logic [PREG_W:0]   fl_recover_free_count_o,

    output logic              ren_valid_o,
    input  logic              ren_ready_i,
    output logic [PREG_W-1:0] ren_prs1_o,
    output logic [PREG_W-1:0] ren_prs2_o,
    output logic [PREG_W-1:0] ren_prd_o,
    output logic [PREG_W-1:0] ren_old_prd_o,
    output logic              ren_rd_we_o,
    output logic              ren_chkpt_valid_o,
    output logic [CK_W-1:0]   ren_chkpt_id_o,

    input  logic              recover_i,
    input  logic [CK_W-1:0]   recover_id_i,
    input  logic              release_i
);

    logic [PREG_W-1:0] map_tbl   [AREG];
    logic [PREG_W-1:0] map_next  [AREG];
    logic [PREG_W-1:0] snap_map  [NCHKPT][AREG];
    logic [PREG_W-1:0] snap_head [NCHKPT];

    logic [CK_W-1:0] ck_head, ck_tail;
    logic [CK_W:0]   ck_count;
    logic [CK_W-1:0] ck_head_n, ck_tail_n;
    logic [CK_W:0]   ck_count_n;

    logic            need_alloc;
    logic            ckpt_full;
    logic            fire;
    logic            ck_push;
    logic            rel_ok;
    logic [CK_W-1:0] rec_dist;
    logic [CK_W:0]   rec_count;
    logic [PREG_W-1:0] rec_gap;

    assign need_alloc = dec_rd_we_i && (dec_rd_i != '0);
    assign ckpt_full  = (ck_count == (CK_W+1)'(NCHKPT));

    assign dec_ready_o = !recover_i
                      && (!ren_valid_o || ren_ready_i)
                      && !(need_alloc && fl_empty_i)
                      && !(dec_branch_i && ckpt_full);

    assign fire          = dec_valid_i && dec_ready_o;
    assign fl_alloc_en_o = fire && need_alloc;
    assign ck_push       = fire && dec_branch_i;

    // Age of the recovered slot relative to the oldest live checkpoint.
    assign rec_dist  = recover_id_i - ck_head;
    assign rec_count = (CK_W+1)'(rec_dist) + (CK_W+1)'(1);

    // Release is measured against the slots that exist before this cycle's push.
    assign rel_ok = release_i && (recover_i || (ck_count != '0));

    // Map as it stands after this cycle's allocation; also what a branch snapshots.
    always_comb begin
        for (int i = 0; i < int'(AREG); i++) begin
            map_next[i] = map_tbl[i];
        end
        if (fl_alloc_en_o) begin
            map_next[dec_rd_i] = fl_alloc_index_i;
        end
    end

    always_comb begin
        ck_head_n  = ck_head;
        ck_tail_n  = ck_tail;
        ck_count_n = ck_count;
        if (recover_i) begin
            ck_tail_n  = recover_id_i + CK_W'(1);
            ck_count_n = rec_count;
        end else if (ck_push) begin
            ck_tail_n  = ck_tail + CK_W'(1);
            ck_count_n = ck_count + (CK_W+1)'(1);
        end
        if (rel_ok) begin
            ck_head_n  = ck_head + CK_W'(1);
            ck_count_n = ck_count_n - (CK_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ck_head  <= '0;
            ck_tail  <= '0;
            ck_count <= '0;
        end else begin
            ck_head  <= ck_head_n;
            ck_tail  <= ck_tail_n;
            ck_count <= ck_count_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(AREG); i++) begin
                map_tbl[i] <= PREG_W'(i);
            end
        end else if (recover_i) begin
            for (int i = 0; i < int'(AREG); i++) begin
                map_tbl[i] <= snap_map[recover_id_i][i];
            end
        end else begin
            for (int i = 0; i < int'(AREG); i++) begin
                map_tbl[i] <= map_next[i];
            end
        end
    end

    // Snapshot storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (ck_push) begin
            for (int i = 0; i < int'(AREG); i++) begin
                snap_map[ck_tail][i] <= map_next[i];
            end
            snap_head[ck_tail] <= fl_chkpt_head_i + PREG_W'(need_alloc);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ren_valid_o       <= 1'b0;
            ren_prs1_o        <= '0;
            ren_prs2_o        <= '0;
            ren_prd_o         <= '0;
            ren_old_prd_o     <= '0;
            ren_rd_we_o       <= 1'b0;
            ren_chkpt_valid_o <= 1'b0;
            ren_chkpt_id_o    <= '0;
        end else if (recover_i) begin
            ren_valid_o <= 1'b0;
        end else if (fire) begin
            ren_valid_o       <= 1'b1;
            ren_prs1_o        <= map_tbl[dec_rs1_i];
            ren_prs2_o        <= map_tbl[dec_rs2_i];
            ren_prd_o         <= need_alloc ? fl_alloc_index_i : '0;
            ren_old_prd_o     <= need_alloc ? map_tbl[dec_rd_i] : '0;
            ren_rd_we_o       <= need_alloc;
            ren_chkpt_valid_o <= dec_branch_i;
            ren_chkpt_id_o    <= dec_branch_i ? ck_tail : '0;
        end else if (ren_ready_i) begin
            ren_valid_o <= 1'b0;
        end
    end

    // Tags popped after the checkpoint go back to the free list; frees are kept.
    assign rec_gap = fl_chkpt_head_i - snap_head[recover_id_i];

    assign fl_recover_o            = recover_i;
    assign fl_recover_head_o       = recover_i ? snap_head[recover_id_i] : '0;
    assign fl_recover_tail_o       = recover_i ? fl_chkpt_tail_i : '0;
    assign fl_recover_free_count_o = recover_i
                                   ? fl_chkpt_free_count_i + (PREG_W+1)'(rec_gap)
                                   : '0;

    a_alloc_done: assert property (@(posedge clk_i) disable iff (rst_i)
        fl_alloc_en_o |-> fl_alloc_done_i);

    a_recover_live: assert property (@(posedge clk_i) disable iff (rst_i)
        recover_i |-> ((CK_W+1)'(rec_dist) < ck_count));

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed scenarios plus random traffic
// against a queue/array model of the rename rules and a simple free list.
module tb_rename_stage;
    localparam int PHYSREG = 128;
    localparam int AREG    = 32;
    localparam int NCHKPT  = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       dec_valid, dec_ready, dec_rd_we, dec_branch;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       fl_alloc_en, fl_alloc_done, fl_empty;
    logic [6:0] fl_alloc_index, fl_chkpt_head, fl_chkpt_tail;
    logic [7:0] fl_chkpt_free_count;
    logic       fl_recover;
    logic [6:0] fl_recover_head, fl_recover_tail;
    logic [7:0] fl_recover_free_count;
    logic       ren_valid, ren_ready, ren_rd_we, ren_chkpt_valid;
    logic [6:0] ren_prs1, ren_prs2, ren_prd, ren_old_prd;
    logic [1:0] ren_chkpt_id, recover_id;
    logic       recover, rel_in;

    // Environment free list: no frees, so the tag at the head is the head index.
    int         fl_head, fl_count;
    logic       force_empty;
    logic [6:0] fl_tail_v;

    assign fl_alloc_index      = 7'(fl_head);
    assign fl_chkpt_head       = 7'(fl_head);
    assign fl_chkpt_tail       = fl_tail_v;
    assign fl_chkpt_free_count = 8'(fl_count);
    assign fl_empty            = (fl_count == 0) || force_empty;
    assign fl_alloc_done       = fl_alloc_en;

    rename_stage dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .dec_valid_i            (dec_valid),
        .dec_ready_o            (dec_ready),
        .dec_rs1_i              (dec_rs1),
        .dec_rs2_i              (dec_rs2),
        .dec_rd_i               (dec_rd),
        .dec_rd_we_i            (dec_rd_we),
        .dec_branch_i           (dec_branch),
        .fl_alloc_en_o          (fl_alloc_en),
        .fl_alloc_done_i        (fl_alloc_done),
        .fl_alloc_index_i       (fl_alloc_index),
        .fl_empty_i             (fl_empty),
        .fl_chkpt_head_i        (fl_chkpt_head),
        .fl_chkpt_tail_i        (fl_chkpt_tail),
        .fl_chkpt_free_count_i  (fl_chkpt_free_count),
        .fl_recover_o           (fl_recover),
        .fl_recover_head_o      (fl_recover_head),
        .fl_recover_tail_o      (fl_recover_tail),
        .fl_recover_free_count_o(fl_recover_free_count),
        .ren_valid_o            (ren_valid),
        .ren_ready_i            (ren_ready),
        .ren_prs1_o             (ren_prs1),
        .ren_prs2_o             (ren_prs2),
        .ren_prd_o              (ren_prd),
        .ren_old_prd_o          (ren_old_prd),
        .ren_rd_we_o            (ren_rd_we),
        .ren_chkpt_valid_o      (ren_chkpt_valid),
        .ren_chkpt_id_o         (ren_chkpt_id),
        .recover_i              (recover),
        .recover_id_i           (recover_id),
        .release_i              (rel_in)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state.
    int mmap [AREG];
    int ck_map [NCHKPT][AREG];
    int ck_hd [NCHKPT];
    int live [$];
    int next_slot;
    bit e_valid, e_we, e_cv;
    int e_prs1, e_prs2, e_prd, e_old, e_id;

    int total = 0;
    int bad   = 0;
    int obs_rec_head, obs_rec_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < AREG; i++) mmap[i] = i;
        live.delete();
        next_slot = 0;
        e_valid = 0; e_we = 0; e_cv = 0;
        e_prs1 = 0; e_prs2 = 0; e_prd = 0; e_old = 0; e_id = 0;
        fl_head  = AREG;
        fl_count = PHYSREG - AREG;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_we = 0; dec_branch = 0;
        ren_ready = 1; recover = 0; recover_id = 0; rel_in = 0; force_empty = 0; fl_tail_v = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        #2 rst_i = 1'b1;
        #1;
        check_val("rst_valid_drop", ren_valid, 0);
        check_val("rst_ready", dec_ready, 1);
        check_val("rst_fl_recover", fl_recover, 0);
        reset_model();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic step(input bit v, input int r1, input int r2, input int rd, input bit we,
                        input bit br, input bit rdy, input bit rec, input int rid,
                        input bit rel, input bit fe);
        bit na, exp_rdy, fire, rel_ok;
        int k, gap, nh, nc;
        @(negedge clk_i);
        dec_valid = v; dec_rs1 = 5'(r1); dec_rs2 = 5'(r2); dec_rd = 5'(rd);
        dec_rd_we = we; dec_branch = br; ren_ready = rdy; recover = rec;
        recover_id = 2'(rid); rel_in = rel; force_empty = fe; fl_tail_v = 7'($urandom);
        #1;
        na      = we && (rd != 0);
        exp_rdy = !rec && (!e_valid || rdy) && !(na && (fl_count == 0 || fe))
                  && !(br && live.size() == NCHKPT);
        check_val("dec_ready", dec_ready, exp_rdy);
        fire = v && exp_rdy;
        check_val("alloc_en", fl_alloc_en, fire && na);
        check_val("fl_recover", fl_recover, rec);
        nh = fl_head; nc = fl_count;
        rel_ok = rel && (rec || live.size() > 0);
        if (rec) begin
            gap = (fl_head - ck_hd[rid] + PHYSREG) % PHYSREG;
            obs_rec_head = fl_recover_head;
            obs_rec_cnt  = fl_recover_free_count;
            check_val("rec_head", fl_recover_head, ck_hd[rid]);
            check_val("rec_tail", fl_recover_tail, fl_tail_v);
            check_val("rec_count", fl_recover_free_count, fl_count + gap);
            nh = ck_hd[rid];
            nc = fl_count + gap;
            k = 0;
            foreach (live[j]) if (live[j] == rid) k = j;
            while (live.size() > k + 1) void'(live.pop_back());
            for (int i = 0; i < AREG; i++) mmap[i] = ck_map[rid][i];
            next_slot = (rid + 1) % NCHKPT;
            e_valid = 0;
        end else if (fire) begin
            e_valid = 1; e_prs1 = mmap[r1]; e_prs2 = mmap[r2]; e_we = na;
            if (na) begin
                e_prd = fl_head; e_old = mmap[rd]; mmap[rd] = fl_head;
                nh = (fl_head + 1) % PHYSREG; nc = fl_count - 1;
            end else begin
                e_prd = 0; e_old = 0;
            end
            e_cv = br; e_id = 0;
            if (br) begin
                e_id = next_slot;
                for (int i = 0; i < AREG; i++) ck_map[next_slot][i] = mmap[i];
                ck_hd[next_slot] = (fl_head + int'(na)) % PHYSREG;
                live.push_back(next_slot);
                next_slot = (next_slot + 1) % NCHKPT;
            end
        end else if (rdy) begin
            e_valid = 0;
        end
        if (rel_ok) void'(live.pop_front());
        @(posedge clk_i);
        #1;
        fl_head = nh; fl_count = nc;
        check_val("ren_valid", ren_valid, e_valid);
        if (e_valid) begin
            check_val("prs1", ren_prs1, e_prs1);
            check_val("prs2", ren_prs2, e_prs2);
            check_val("prd", ren_prd, e_prd);
            check_val("old_prd", ren_old_prd, e_old);
            check_val("rd_we", ren_rd_we, e_we);
            check_val("chkpt_valid", ren_chkpt_valid, e_cv);
            if (e_cv) check_val("chkpt_id", ren_chkpt_id, e_id);
        end
    endtask

    initial begin
        bit rv, rwe, rbr, rrdy, rrec, rrel, rfe;
        int rid;
        rst_i = 1'b1;
        idle_inputs();
        reset_model();
        #12;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_val("reset_valid", ren_valid, 0);
        check_val("reset_prd", ren_prd, 0);
        check_val("reset_id", ren_chkpt_id, 0);
        check_val("reset_ready", dec_ready, 1);
        check_val("reset_fl_recover", fl_recover, 0);

        // add x5, x1, x2 then x6 = x5
        step(1, 1, 2, 5, 1, 0, 1, 0, 0, 0, 0);
        check_val("d_prs1", ren_prs1, 1);
        check_val("d_prs2", ren_prs2, 2);
        check_val("d_prd", ren_prd, 32);
        check_val("d_old", ren_old_prd, 5);
        step(1, 5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
        check_val("d_dep_prs1", ren_prs1, 32);
        check_val("d_dep_prd", ren_prd, 33);

        // x0 write and rs == rd
        step(1, 3, 4, 0, 1, 0, 1, 0, 0, 0, 0);
        check_val("d_x0_prd", ren_prd, 0);
        check_val("d_x0_we", ren_rd_we, 0);
        step(1, 7, 7, 7, 1, 0, 1, 0, 0, 0, 0);
        check_val("d_x7_prs1", ren_prs1, 7);
        check_val("d_x7_old", ren_old_prd, 7);
        check_val("d_x7_prd", ren_prd, 34);

        // Backpressure: outputs hold, nothing allocates
        repeat (3) step(1, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
        check_val("d_hold_prd", ren_prd, 34);
        step(1, 1, 1, 8, 1, 0, 1, 0, 0, 0, 0);
        // Empty free list: writer stalls, non-writer passes
        step(1, 1, 2, 9, 1, 0, 1, 0, 0, 0, 1);
        step(1, 1, 2, 9, 0, 0, 1, 0, 0, 0, 1);
        check_val("d_empty_pass", ren_valid, 1);

        // Checkpoint full
        do_reset();
        for (int i = 0; i < NCHKPT; i++) begin
            step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
            check_val("d_ck_id", ren_chkpt_id, i);
        end
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        check_val("d_ck_wrap_id", ren_chkpt_id, 0);

        // Recover to slot 1 taken at head 40
        do_reset();
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step(1, 0, 0, i, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        check_val("d_rec_slot", ren_chkpt_id, 1);
        step(1, 0, 0, 9, 1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 10, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 11, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 12, 1, 0, 1, 1, 1, 0, 0);
        check_val("d_rec_head", obs_rec_head, 40);
        check_val("d_rec_cnt", obs_rec_cnt, 88);
        check_val("d_rec_valid", ren_valid, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        check_val("d_rec_reuse_id", ren_chkpt_id, 2);
        step(1, 9, 8, 0, 0, 0, 1, 0, 0, 0, 0);
        check_val("d_rec_map9", ren_prs1, 9);
        check_val("d_rec_map8", ren_prs2, 39);

        // Reset with a valid output pending
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        check_val("d_pre_rst_valid", ren_valid, 1);
        do_reset();
        step(1, 5, 6, 0, 0, 0, 1, 0, 0, 0, 0);
        check_val("d_post_rst_map", ren_prs1, 5);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            rv   = ($urandom_range(0, 3) != 0);
            rwe  = ($urandom_range(0, 3) != 0);
            rbr  = ($urandom_range(0, 3) == 0);
            rrdy = ($urandom_range(0, 3) != 0);
            rrec = (live.size() > 0) && ($urandom_range(0, 11) == 0);
            rid  = rrec ? live[$urandom_range(0, live.size() - 1)] : int'($urandom_range(0, 3));
            rrel = ($urandom_range(0, 5) == 0);
            rfe  = ($urandom_range(0, 9) == 0);
            step(rv, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 rwe, rbr, rrdy, rrec, rid, rrel, rfe);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
